// File: rtl/sram_fifo_ctrl.sv
// FIFO controller that streams valid/ready words through a single-port synchronous RAM.
// Reads win arbitration; a read spends one cycle in RD_WAIT before its data lands in out_data.
module sram_fifo_ctrl #(
   parameter int n = 8,
   parameter int m = 10
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         in_valid,
   input  logic [n-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [n-1:0] out_data,
   input  logic         out_ready,
   output logic         sram_rw,
   output logic [m-1:0] sram_addr,
   output logic [n-1:0] sram_din,
   input  logic [n-1:0] sram_dout,
   output logic         o_full,
   output logic         o_empty
);

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   localparam logic [m:0] DEPTH = {1'b1, {m{1'b0}}};

   state_t         state;
   state_t         state_next;
   logic [m-1:0]   wr_ptr;
   logic [m-1:0]   rd_ptr;
   logic [m:0]     count;
   logic           rd_go;
   logic           wr_go;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (rd_go) state_next = RD_WAIT;
         RD_WAIT: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A read may issue only when the holding register is free or being emptied this cycle.
   always_comb begin
      rd_go     = (state == IDLE) && (count != '0) && (!out_valid || out_ready);
      o_full    = (count == DEPTH);
      in_ready  = !rd_go && !o_full;
      wr_go     = in_valid && in_ready;
      sram_rw   = !wr_go;
      sram_addr = wr_go ? wr_ptr : rd_ptr;
      sram_din  = in_data;
      o_empty   = (count == '0) && (state == IDLE) && !out_valid;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (wr_go) begin
            wr_ptr <= wr_ptr + m'(1);
            count  <= count + (m+1)'(1);
         end else if (rd_go) begin
            rd_ptr <= rd_ptr + m'(1);
            count  <= count - (m+1)'(1);
         end
         // A capture in the same edge as a pop keeps out_valid high with the new word.
         if (state == RD_WAIT) begin
            out_data  <= sram_dout;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl at m=3: behavioural RAM, queue scoreboard, directed and random traffic.
module tb_sram_fifo_ctrl;

   localparam int N     = 8;
   localparam int M     = 3;
   localparam int DEPTH = 8;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b0;
   logic         in_valid = 1'b0;
   logic [N-1:0] in_data = '0;
   logic         in_ready;
   logic         out_valid;
   logic [N-1:0] out_data;
   logic         out_ready = 1'b0;
   logic         sram_rw;
   logic [M-1:0] sram_addr;
   logic [N-1:0] sram_din;
   logic [N-1:0] sram_dout = '0;
   logic         o_full;
   logic         o_empty;

   logic [N-1:0] sram_mem [0:DEPTH-1];

   int checks = 0;
   int failures = 0;
   logic [N-1:0] model_q [$];
   int  wr_count = 0;
   int  out_count = 0;
   int  last_wr_addr = -1;
   logic saw_wrap = 1'b0;
   logic hold_valid = 1'b0;
   logic [N-1:0] hold_data = '0;
   logic last_push = 1'b0;
   logic last_pop = 1'b0;

   sram_fifo_ctrl #(.n(N), .m(M)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sram_rw   (sram_rw),
      .sram_addr (sram_addr),
      .sram_din  (sram_din),
      .sram_dout (sram_dout),
      .o_full    (o_full),
      .o_empty   (o_empty)
   );

   always #5 i_clk = ~i_clk;

   // Behavioural single-port RAM: write on rw=0, otherwise read with data held until next read.
   always @(posedge i_clk) begin
      if (!sram_rw) sram_mem[sram_addr] <= sram_din;
      else sram_dout <= sram_mem[sram_addr];
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] = '0;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [N-1:0] d, input logic r);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1;
   endtask

   task automatic resetModel();
      model_q.delete();
      wr_count     = 0;
      last_wr_addr = -1;
      saw_wrap     = 1'b0;
      hold_valid   = 1'b0;
   endtask

   task automatic doReset();
      i_rst = 1'b1;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      resetModel();
   endtask

   // One clock: scoreboard handshakes seen before the edge, then compare o_empty after it.
   task automatic clockCycle();
      logic push_hs;
      logic pop_hs;
      logic [N-1:0] pushed;
      push_hs = in_valid && in_ready;
      pop_hs  = out_valid && out_ready;
      pushed  = in_data;
      if (pop_hs) begin
         if (model_q.size() == 0) checkOutput("pop_underflow", 32'(1), 32'(0));
         else checkOutput("pop_data", 32'(out_data), 32'(model_q[0]));
      end
      if (!sram_rw) begin
         checkOutput("wr_addr", 32'(sram_addr), 32'(wr_count % DEPTH));
         checkOutput("wr_din", 32'(sram_din), 32'(in_data));
         checkOutput("wr_without_push", 32'(push_hs), 32'(1));
         if (last_wr_addr == DEPTH-1 && sram_addr == '0) saw_wrap = 1'b1;
         last_wr_addr = int'(sram_addr);
      end
      if (hold_valid && out_valid) checkOutput("hold_stable", 32'(out_data), 32'(hold_data));
      if (o_full) checkOutput("full_blocks_push", 32'(in_ready), 32'(0));
      hold_valid = out_valid && !out_ready;
      hold_data  = out_data;
      @(posedge i_clk);
      if (push_hs) begin
         model_q.push_back(pushed);
         wr_count++;
      end
      if (pop_hs && model_q.size() != 0) begin
         void'(model_q.pop_front());
         out_count++;
      end
      last_push = push_hs;
      last_pop  = pop_hs;
      @(negedge i_clk);
      checkOutput("empty_flag", 32'(o_empty), 32'(model_q.size() == 0));
   endtask

   task automatic drainFifo(input string tag);
      int c;
      c = 0;
      while (!o_empty && c < 100) begin
         applyStimulus(1'b0, '0, 1'b1);
         clockCycle();
         c++;
      end
      checkOutput({tag, "_drained"}, 32'(o_empty), 32'(1));
      checkOutput({tag, "_model_empty"}, 32'(model_q.size()), 32'(0));
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int next;
      int cyc;
      int start;
      int pushed_n;
      logic cur_valid;
      logic [N-1:0] cur_data;
      logic [N-1:0] exp_words [0:2];
      logic exp_valid [0:4];

      #1;
      doReset();
      $display("[TB] reset values");
      checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
      checkOutput("rst_sram_rw", 32'(sram_rw), 32'(1));
      checkOutput("rst_sram_addr", 32'(sram_addr), 32'(0));
      checkOutput("rst_full", 32'(o_full), 32'(0));
      checkOutput("rst_empty", 32'(o_empty), 32'(1));
      checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
      checkOutput("rst_out_data", 32'(out_data), 32'(0));

      $display("[TB] single push latency");
      applyStimulus(1'b1, 8'd32, 1'b1);
      checkOutput("t1_c0_rw", 32'(sram_rw), 32'(0));
      checkOutput("t1_c0_addr", 32'(sram_addr), 32'(0));
      checkOutput("t1_c0_din", 32'(sram_din), 32'(32));
      clockCycle();
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("t1_c1_rw", 32'(sram_rw), 32'(1));
      checkOutput("t1_c1_addr", 32'(sram_addr), 32'(0));
      checkOutput("t1_c1_in_ready", 32'(in_ready), 32'(0));
      clockCycle();
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("t1_c2_out_valid", 32'(out_valid), 32'(0));
      checkOutput("t1_c2_empty", 32'(o_empty), 32'(0));
      clockCycle();
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("t1_c3_out_valid", 32'(out_valid), 32'(1));
      checkOutput("t1_c3_out_data", 32'(out_data), 32'(32));
      clockCycle();
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("t1_c4_empty", 32'(o_empty), 32'(1));

      $display("[TB] back-to-back pushes then paced pops");
      doReset();
      applyStimulus(1'b1, 8'd32, 1'b0);
      checkOutput("t2_c0_in_ready", 32'(in_ready), 32'(1));
      clockCycle();
      applyStimulus(1'b1, 8'd47, 1'b0);
      checkOutput("t2_c1_in_ready", 32'(in_ready), 32'(0));
      checkOutput("t2_c1_rw", 32'(sram_rw), 32'(1));
      clockCycle();
      applyStimulus(1'b1, 8'd47, 1'b0);
      checkOutput("t2_c2_in_ready", 32'(in_ready), 32'(1));
      checkOutput("t2_c2_addr", 32'(sram_addr), 32'(1));
      clockCycle();
      applyStimulus(1'b1, 8'd14, 1'b0);
      checkOutput("t2_c3_in_ready", 32'(in_ready), 32'(1));
      checkOutput("t2_c3_addr", 32'(sram_addr), 32'(2));
      checkOutput("t2_c3_out_valid", 32'(out_valid), 32'(1));
      clockCycle();
      exp_words[0] = 8'd32; exp_words[1] = 8'd47; exp_words[2] = 8'd14;
      exp_valid[0] = 1'b1; exp_valid[1] = 1'b0; exp_valid[2] = 1'b1;
      exp_valid[3] = 1'b0; exp_valid[4] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, '0, 1'b1);
         checkOutput($sformatf("t2_pop%0d_valid", i), 32'(out_valid), 32'(exp_valid[i]));
         if (exp_valid[i]) checkOutput($sformatf("t2_pop%0d_data", i), 32'(out_data), 32'(exp_words[i/2]));
         clockCycle();
      end
      drainFifo("t2");

      $display("[TB] fill to full");
      doReset();
      next = 0; cyc = 0;
      while (next < 9 && cyc < 60) begin
         applyStimulus(1'b1, 8'(next), 1'b0);
         clockCycle();
         if (last_push) next++;
         cyc++;
      end
      checkOutput("t3_fill_done", 32'(next), 32'(9));
      applyStimulus(1'b1, 8'd9, 1'b0);
      checkOutput("t3_full", 32'(o_full), 32'(1));
      checkOutput("t3_in_ready", 32'(in_ready), 32'(0));
      checkOutput("t3_held_valid", 32'(out_valid), 32'(1));
      checkOutput("t3_held_data", 32'(out_data), 32'(0));
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'd9, 1'b0);
         checkOutput("t3_stall_ready", 32'(in_ready), 32'(0));
         checkOutput("t3_stall_no_write", 32'(sram_rw), 32'(1));
         clockCycle();
      end
      applyStimulus(1'b1, 8'd9, 1'b1);
      checkOutput("t3_issue_ready", 32'(in_ready), 32'(0));
      clockCycle();
      applyStimulus(1'b1, 8'd9, 1'b0);
      checkOutput("t3_reopen_ready", 32'(in_ready), 32'(1));
      checkOutput("t3_reopen_full", 32'(o_full), 32'(0));
      clockCycle();
      checkOutput("t3_push9_taken", 32'(last_push), 32'(1));
      drainFifo("t3");

      $display("[TB] continuous stream with wrap");
      doReset();
      start = out_count; next = 0; cyc = 0;
      while (next < 20 && cyc < 200) begin
         applyStimulus(1'b1, 8'(next), 1'b1);
         clockCycle();
         if (last_push) next++;
         cyc++;
      end
      checkOutput("t4_pushed", 32'(next), 32'(20));
      drainFifo("t4");
      checkOutput("t4_popped", 32'(out_count - start), 32'(20));
      checkOutput("t4_wrap", 32'(saw_wrap), 32'(1));

      $display("[TB] asynchronous reset during read wait");
      doReset();
      applyStimulus(1'b1, 8'd100, 1'b0); clockCycle();
      applyStimulus(1'b1, 8'd101, 1'b0); clockCycle();
      applyStimulus(1'b1, 8'd101, 1'b0); clockCycle();
      applyStimulus(1'b0, '0, 1'b0);     clockCycle();
      applyStimulus(1'b0, '0, 1'b1);     clockCycle();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("t5_pre_addr", 32'(sram_addr), 32'(2));
      checkOutput("t5_pre_empty", 32'(o_empty), 32'(0));
      #2;
      i_rst = 1'b1;
      #1;
      checkOutput("t5_rst_out_valid", 32'(out_valid), 32'(0));
      checkOutput("t5_rst_addr", 32'(sram_addr), 32'(0));
      checkOutput("t5_rst_empty", 32'(o_empty), 32'(1));
      checkOutput("t5_rst_in_ready", 32'(in_ready), 32'(1));
      checkOutput("t5_rst_out_data", 32'(out_data), 32'(0));
      resetModel();
      @(negedge i_clk);
      i_rst = 1'b0;
      applyStimulus(1'b1, 8'd5, 1'b0);
      checkOutput("t5_post_addr", 32'(sram_addr), 32'(0));
      clockCycle();
      cyc = 0;
      while (!out_valid && cyc < 10) begin
         applyStimulus(1'b0, '0, 1'b0);
         clockCycle();
         cyc++;
      end
      checkOutput("t5_first_valid", 32'(out_valid), 32'(1));
      checkOutput("t5_first_data", 32'(out_data), 32'(5));
      drainFifo("t5");

      $display("[TB] random traffic");
      doReset();
      start = out_count; pushed_n = 0; cyc = 0;
      cur_valid = 1'b0; cur_data = '0;
      while (pushed_n < 200 && cyc < 6000) begin
         if (!cur_valid) begin
            cur_valid = ($urandom_range(0, 3) != 0);
            cur_data  = 8'($urandom_range(0, 255));
         end
         applyStimulus(cur_valid, cur_data, 1'($urandom_range(0, 1)));
         clockCycle();
         if (last_push) begin
            cur_valid = 1'b0;
            pushed_n++;
         end
         cyc++;
      end
      checkOutput("t6_pushed", 32'(pushed_n), 32'(200));
      drainFifo("t6");
      checkOutput("t6_popped", 32'(out_count - start), 32'(200));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Single-clock FIFO controller that uses the single-port synchronous RAM SRAM_V as its storage array. It sits directly upstream of SRAM_V: it converts a valid/ready push stream and a valid/ready pop stream into the RAM's `rw`/`addr_in`/`d_in` accesses and captures `data_out`. It lets producer and consumer logic stream words through the RAM without hand-sequencing addresses.

## Interface

Parameters:
- `n`, default 8: data width; must match SRAM_V `n`.
- `m`, default 10: address width; depth = 2**m.

Ports (one clock; reset is asynchronous and active-high):
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  producer has a word.
- `in_data`  in  n  word to push.
- `in_ready`  out  1  controller accepts `in_data` this cycle.
- `out_valid`  out  1  `out_data` holds the oldest word.
- `out_data`  out  n  popped word; registered.
- `out_ready`  in  1  consumer takes `out_data` this cycle.
- `sram_rw`  out  1  to SRAM_V `rw`: 0 = write, 1 = read.
- `sram_addr`  out  m  to SRAM_V `addr_in`.
- `sram_din`  out  n  to SRAM_V `d_in`.
- `sram_dout`  in  n  from SRAM_V `data_out`.
- `o_full`  out  1  RAM holds 2**m words.
- `o_empty`  out  1  no word anywhere in the controller or RAM.

## Operation

- SRAM_V contract:
  - It samples `rw`/`addr_in`/`d_in` on the rising `i_clk` edge.
  - `rw=0` writes `d_in`.
  - `rw=1` reads; `data_out` is valid in the cycle after the edge and is held until the next read.
- Registers:
  - `wr_ptr[m-1:0]` and `rd_ptr[m-1:0]` wrap modulo 2**m.
  - `count[m:0]` counts words resident in the RAM.
  - `state` is IDLE or RD_WAIT.
  - Output holding register: `out_data`/`out_valid`.
- One RAM access per cycle. The arbitration decision is combinational each cycle:
  - **rd_go** = (state==IDLE) && (count!=0) && (!out_valid || out_ready).
  - **wr_go** = in_valid && in_ready, with in_ready = !rd_go && (count != 2**m).
  - Reads have priority over writes.
- RAM drive:
  - If wr_go: sram_rw=0, sram_addr=wr_ptr, sram_din=in_data.
  - Otherwise: sram_rw=1, sram_addr=rd_ptr, sram_din=in_data (don't-care).
- wr_go edge: wr_ptr+1, count+1.
- rd_go edge: rd_ptr+1, count−1, state IDLE→RD_WAIT.
- RD_WAIT cycle:
  - Writes are permitted.
  - At the closing edge: out_data<=sram_dout, out_valid<=1, state→IDLE.
- out_valid clears on out_valid && out_ready, unless the same edge captures new data (RD_WAIT); in that case out_valid stays 1 with the new word.
- Flags:
  - o_full = (count == 2**m).
  - o_empty = (count==0) && (state==IDLE) && !out_valid.
- Count never has simultaneous increment and decrement; wr_go and rd_go are mutually exclusive.

## Timing

- Reset values:
  - Pointers 0, count 0, state IDLE.
  - out_valid 0, out_data 0.
  - in_ready 1, sram_rw 1, sram_addr 0, o_full 0, o_empty 1.
- Reset mid-operation:
  - An in-flight read is discarded and the held word is lost.
  - RAM contents are not cleared; pointers make the old contents unreachable.
- Latency into an empty FIFO: a push accepted in cycle 0 issues its read in cycle 1, is in RD_WAIT in cycle 2, and has out_valid=1 in cycle 3.
- Pop throughput: at most one word per 2 cycles (issue + RD_WAIT). In RD_WAIT, push throughput is one per cycle.
- Holding register full with out_ready=0: no read issues, and pushes proceed at one per cycle until full.
- Full:
  - in_ready=0 and no RAM write.
  - An accepted pop reopens in_ready, earliest in the cycle after the read issue.
- wr_ptr wraps from 2**m−1 to 0, and rd_ptr likewise, with no gap.
- in_valid with in_ready=0: the producer must hold in_data. The consumer sees out_data stable while out_valid && !out_ready.

## Test plan

- Reset, then push 32 with out_ready=1:
  - sram_rw=0 with sram_addr=0 and sram_din=32 in cycle 0.
  - Read of addr 0 in cycle 1.
  - out_valid=1 with out_data=32 in cycle 3; o_empty=1 afterwards.
- Push 32, 47, 14 back-to-back with out_ready=0:
  - Writes go to addresses 0, 1, 2 in order, with in_ready=0 only in the cycle a read issues.
  - Raising out_ready then yields 32, 47, 14 in order, one per 2 cycles.
- With m=3, push 8 words (0..7) with out_ready=0:
  - The first word is held in out_data, then 7 words remain in the RAM.
  - Push the 9th word: RAM count reaches 8, o_full=1, in_ready=0, and the 10th push stalls with in_data held.
- Wrap-around with m=3: stream 20 words at continuous push/pop.
  - Output order is 0..19 with no loss or duplication.
  - sram_addr wraps 7→0.
- Assert i_rst mid-stream (asynchronous, between edges) during RD_WAIT:
  - Outputs go to reset values immediately.
  - After release, a push of 5 appears as the first output.
- out_ready toggled randomly for 200 pushes: the output sequence is identical to the input sequence, and out_data never changes while out_valid && !out_ready.
